// File: rtl/vram_write_queue.sv
// CPU-side VRAM write buffer: a small FIFO drained into the VRAM write port while
// video timing allows writes. Optional object-hide sweep via `VWQ_OBM_HIDE_EN.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 11
`endif

module vram_write_queue #(
    parameter int          DEPTH    = 8,
    parameter int          ADDR_W   = `VRAM_ADDR_WIDTH,
    parameter int unsigned OBM_BASE = 'h200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic [7:0]               in_data,
    input  logic                     writable,
    output logic                     vram_we,
    output logic [ADDR_W-1:0]        vram_address,
    output logic [7:0]               vram_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
`ifdef VWQ_OBM_HIDE_EN
    ,
    input  logic                     hide_req,
    output logic                     hide_done
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 8;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

`ifdef VWQ_OBM_HIDE_EN
    typedef enum logic [1:0] {IDLE, DRAIN, HIDE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAIN} state_t;
`endif

    state_t               state_q, state_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 vram_we_q, vram_we_d;
    logic [ADDR_W-1:0]    vram_address_q, vram_address_d;
    logic [7:0]           vram_data_q, vram_data_d;
    logic                 busy_q, busy_d;
    logic                 ready_en_q, ready_en_d;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [ENTRY_W-1:0]   head_entry;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 hide_block;

`ifdef VWQ_OBM_HIDE_EN
    localparam logic [ADDR_W-1:0] OBM_BASE_A = ADDR_W'(OBM_BASE);

    logic                 hide_pending_q, hide_pending_d;
    logic [5:0]           idx_q, idx_d;
    logic                 sweep_last_q, sweep_last_d;
    logic                 hide_done_q, hide_done_d;
    logic [ADDR_W-1:0]    sweep_addr;

    // Byte 1 (YP) of object idx; sum wraps at the address width.
    assign sweep_addr = OBM_BASE_A + ADDR_W'({idx_q, 2'b01});
    assign hide_block = hide_pending_q || (state_q == HIDE);
`else
    assign hide_block = 1'b0;
`endif

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign in_ready   = rst && ready_en_q && !full && !hide_block;
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == DRAIN) && !empty && writable;
    assign head_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q + LVL_W'(push) - LVL_W'(pop);
        vram_we_d      = 1'b0;
        vram_address_d = vram_address_q;
        vram_data_d    = vram_data_q;
        ready_en_d     = 1'b1;
`ifdef VWQ_OBM_HIDE_EN
        hide_pending_d = hide_pending_q;
        idx_d          = idx_q;
        sweep_last_d   = 1'b0;
        hide_done_d    = sweep_last_q;
        if (hide_req && !hide_pending_q && (state_q != HIDE)) begin
            hide_pending_d = 1'b1;
        end
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d       = rd_ptr_q + PTR_ONE;
            vram_we_d      = 1'b1;
            vram_address_d = head_entry[ENTRY_W-1:8];
            vram_data_d    = head_entry[7:0];
        end

        case (state_q)
            IDLE: begin
`ifdef VWQ_OBM_HIDE_EN
                if (hide_pending_q && empty) begin
                    state_d        = HIDE;
                    hide_pending_d = 1'b0;
                end else if (level_d != '0) begin
                    state_d = DRAIN;
                end
`else
                if (level_d != '0) begin
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (level_d == '0) begin
                    state_d = IDLE;
                end
            end
`ifdef VWQ_OBM_HIDE_EN
            HIDE: begin
                // Closed window pauses the sweep without advancing the index.
                if (writable) begin
                    vram_we_d      = 1'b1;
                    vram_address_d = sweep_addr;
                    vram_data_d    = 8'hFF;
                    idx_d          = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d      = IDLE;
                        sweep_last_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (level_d != '0) || vram_we_d;
`ifdef VWQ_OBM_HIDE_EN
        busy_d = busy_d || hide_pending_d || (state_d == HIDE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            vram_we_q      <= 1'b0;
            vram_address_q <= '0;
            vram_data_q    <= '0;
            busy_q         <= 1'b0;
            ready_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            vram_we_q      <= vram_we_d;
            vram_address_q <= vram_address_d;
            vram_data_q    <= vram_data_d;
            busy_q         <= busy_d;
            ready_en_q     <= ready_en_d;
        end
    end

`ifdef VWQ_OBM_HIDE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hide_pending_q <= 1'b0;
            idx_q          <= '0;
            sweep_last_q   <= 1'b0;
            hide_done_q    <= 1'b0;
        end else begin
            hide_pending_q <= hide_pending_d;
            idx_q          <= idx_d;
            sweep_last_q   <= sweep_last_d;
            hide_done_q    <= hide_done_d;
        end
    end

    assign hide_done = hide_done_q;
`endif

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_address, in_data};
        end
    end

    assign vram_we      = vram_we_q;
    assign vram_address = vram_address_q;
    assign vram_data    = vram_data_q;
    assign level        = level_q;
    assign busy         = busy_q;

endmodule

// File: doc/vram_write_queue.md
# vram_write_queue

Buffers CPU-side VRAM writes (pattern memory, object memory, etc.) in a small FIFO and commits them to the GPU's VRAM write port only while the video timing marks VRAM as writable. It is the writer counterpart of the foreground/background renderers, which read PMF/OBM. It sits between the bus bridge and the VRAM arrays, so the CPU never stalls on the raster window except when the queue is full. An optional sweep engine hides all 64 objects in one command.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `ADDR_W`, default `` `VRAM_ADDR_WIDTH ``: VRAM address width.
- `OBM_BASE`, default 'h200: VRAM address of object 0 byte 0. Objects are 4 bytes each; byte 1 is YP.

Ports:
- `clk` in 1: GPU pixel clock, 12.5875 MHz.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: write request present.
- `in_ready` out 1: queue can accept a request.
- `in_address` in ADDR_W: target VRAM address.
- `in_data` in 8: target byte.
- `writable` in 1: VRAM write window from video timing.
- `vram_we` out 1: write strobe, one byte per cycle.
- `vram_address` out ADDR_W: write address.
- `vram_data` out 8: write data.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: queue is non-empty, a sweep is pending or active, or a write is in flight.
- `hide_req` in 1: start an object-hide sweep. Present only with the macro.
- `hide_done` out 1: one-cycle pulse at sweep end. Present only with the macro.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, {in_address, in_data} is written at the tail.
- `in_ready = !full && !hide_pending && state != HIDE`.
  - A push is refused when full, even if a pop occurs in the same cycle.
- States: IDLE, DRAIN, HIDE.
  - IDLE→DRAIN when the FIFO is non-empty.
  - DRAIN→IDLE when the FIFO becomes empty.
  - IDLE→HIDE when `hide_pending` is set and the FIFO is empty.
  - HIDE→IDLE after write 63 is issued.
- Pop and issue in DRAIN: on an edge where `writable=1` and the FIFO is non-empty, the head entry is popped into the output registers. `vram_we` is 1 for exactly the following cycle. Otherwise `vram_we=0` for that cycle.
- Order: entries are written in push order. No coalescing; duplicate addresses are both written.
- Simultaneous push and pop: allowed when not full; `level` is unchanged.
- Sweep: `hide_req` sets `hide_pending`.
  - Entries already queued drain first; new pushes are blocked from that point.
  - In HIDE, the index i counts 0..63. Each edge with `writable=1` issues address = OBM_BASE + 4·i + 1, data = 8'hFF, then i increments. Cycles with `writable=0` pause without advancing i.
  - `hide_req` while pending or in HIDE is ignored.
- Arithmetic: all address sums are modulo 2^ADDR_W. FIFO pointers are $clog2(DEPTH) bits with wrap-around; full/empty use an extra wrap bit.

## Timing
- Reset values: `vram_we=0`, `vram_address=0`, `vram_data=0`, `level=0`, `busy=0`, `in_ready=0` while in reset, `hide_done=0`, state IDLE, `hide_pending=0`, i=0.
  - `in_ready` rises on the first cycle after `rst` deasserts.
- Latency: entry pushed at edge N into an empty FIFO with `writable` high:
  - popped at edge N+1;
  - `vram_we` high during cycle N+1→N+2.
- Throughput: one write per cycle while `writable` stays high.
- Window tail: `writable` is sampled at the issue edge. A write issued on the last writable edge has its strobe in the cycle after `writable` falls. The VRAM port must accept it.
- `hide_done` goes high for one cycle, in the cycle after write 63's strobe cycle.
- Reset mid-operation: the FIFO is flushed and any in-flight strobe is dropped (`vram_we=0` on the next cycle). A sweep in progress is abandoned and `hide_done` does not pulse.
- All outputs except `in_ready` are registered.

## Configuration
- `VWQ_OBM_HIDE_EN` defined:
  - the `hide_req`/`hide_done` ports, `hide_pending`, and the HIDE state exist, as described.
- `VWQ_OBM_HIDE_EN` undefined:
  - no `hide_req`/`hide_done` ports;
  - states are IDLE and DRAIN only;
  - `in_ready = !full`.

## Test plan
- Reset then single write: push (0x012, 0xA5) with `writable=1` → one cycle of `vram_we` with address 0x012 and data 0xA5, two edges after the push; `level` returns to 0.
- Fill while not writable: push 8 entries with `writable=0` → `level=8`, `in_ready=0`, no `vram_we`. Then raise `writable` → 8 consecutive strobes in push order, and `in_ready` rises once `level<8`.
- Window gaps: 5 queued entries with `writable` toggling 1,0,0,1,1,0,1,1 → exactly 5 strobes, one per sampled-high edge, order preserved; the last strobe may fall in a `writable=0` cycle.
- Simultaneous push/pop at `level=3` with `writable=1` → `level` stays 3 and the head is written.
- Sweep (macro on): 2 queued entries then `hide_req` → the 2 entries are written first. Then 64 writes of 0xFF to 0x201, 0x205, …, 0x2FD, pausing whenever `writable=0`. `hide_done` pulses once; `in_ready=0` throughout.
- Reset mid-drain with 4 entries queued → no further strobes, `level=0`, `busy=0` after reset release.
